pulse_analyzer: RTL and testbench
=================================

# pulse_analyzer

Measures the high time and period of a single-bit pulse train sampled in the `clk` domain, the receiving counterpart of the PWM pulse generator core. Each complete period (rising edge to next rising edge) yields one width/period measurement with a one-cycle `valid` strobe, a saturation flag and a running measurement count. It sits on an FPGA input pin or loopback path and feeds status registers read over the control bus.

## Interface
- `PULSE_WIDTH_WIDTH`, 8: width of the high-time counter and `width` output.
- `PULSE_PERIOD_WIDTH`, 16: width of the period counter and `period` output.
- `clk  input  1  single clock; all logic on rising edge`
- `resetn  input  1  synchronous reset, active-low`
- `din  input  1  pulse train to analyse`
- `width  output  PULSE_WIDTH_WIDTH  high cycles of the last complete period`
- `period  output  PULSE_PERIOD_WIDTH  cycles between the last two rising edges`
- `valid  output  1  one-cycle strobe: width/period/overflow updated`
- `overflow  output  1  last measurement saturated (width or period)`
- `count  output  32  number of valid strobes since reset, wraps at 2^32`

## Operation
- Edge detection: `d` is the sampled input (`din`, or the synchronizer output, see Configuration); `d_q` is `d` delayed by one register. Rise = `d & ~d_q`; fall = `~d & d_q`. `d_q` resets to 1, so a `din` high at reset release is not treated as a rise.
- States:
  - IDLE (reset state): wait for `d`=0, then go to ARMED.
  - ARMED: on rise, go to HIGH and load both counters with 1; no strobe.
  - HIGH: both counters increment per cycle while `d`=1; on fall, go to LOW; width counter freezes.
  - LOW: period counter increments.
    - On rise: drive `width`←width counter, `period`←period counter and `overflow`←sticky flag; pulse `valid`; increment `count`.
    - Then reload both counters with 1, clear the sticky flag and go to HIGH.
- Saturation: each counter holds at all-ones instead of wrapping; reaching all-ones sets the sticky overflow flag for the current measurement. Outputs carry the saturated value, e.g. `period`=16'hFFFF.
- A pulse one cycle wide passes through HIGH for one cycle, giving `width`=1. Minimum measurable pattern is W=1, P=2.
- `width`, `period`, `overflow` hold their values between strobes. `valid` is high for exactly one cycle per strobe.
- Reset mid-measurement discards the partial measurement and returns to IDLE. The next strobe comes only after `din` low, then a full period.

## Timing
- Reset values: `width`=0, `period`=0, `valid`=0, `overflow`=0, `count`=0, state IDLE.
- Latency without sync: `valid` rises in the cycle after the clock edge that first samples `din`=1 following a low. With sync: 2 cycles later.
- For `din` from the generator with width W and period P (1≤W<P), `valid` repeats every P cycles with `width`=W, `period`=P.
- The first rise after reset or IDLE produces no strobe. The first strobe is at the second rise.
- `count` updates in the same cycle as `valid`.

## Configuration
- `PULSE_ANALYZER_SYNC_EN` defined:
  - `din` passes through a two-flop synchronizer (both flops reset to 1) before edge detection.
  - Suitable for asynchronous pins; adds 2 cycles of latency; measured values are unchanged.
- Undefined: `din` is used directly and must be synchronous to `clk`.

## Test plan
- Generator loopback, W=3, P=10, for 5 periods -> 4 strobes spaced 10 cycles apart, each with `width`=3, `period`=10, `overflow`=0; `count`=4.
- Boundary patterns W=1,P=2 and W=9,P=10 -> strobes every 2 and every 10 cycles, reporting (1,2) and (9,10) respectively.
- `din` held high across reset release for 20 cycles, then generator W=4, P=8 -> no strobe until the second rise; first strobe reports `width`=4, `period`=8.
- Rise, 70000 cycles low, rise -> `period`=16'hFFFF, `overflow`=1. The next normal period (W=2, P=5) reports `overflow`=0.
- Rise, 300 cycles high, fall, then rise at cycle 400 -> `width`=8'hFF, `period`=400, `overflow`=1.
- `resetn` low for 1 cycle during HIGH -> all outputs 0 and `count`=0 next cycle. No strobe until `din` low, then a rise, then a full period.

Source files
------------

// File: rtl/pulse_analyzer_if.sv
// Signal bundle between a pulse source / status reader and pulse_analyzer.
// The master drives din and reads the measurement; the slave is the analyzer.
interface pulse_analyzer_if #(
  parameter int PULSE_WIDTH_WIDTH  = 8,
  parameter int PULSE_PERIOD_WIDTH = 16
);
  logic                          din;
  logic [PULSE_WIDTH_WIDTH-1:0]  width;
  logic [PULSE_PERIOD_WIDTH-1:0] period;
  logic                          valid;
  logic                          overflow;
  logic [31:0]                   count;

  modport master (output din, input width, period, valid, overflow, count);
  modport slave  (input din, output width, period, valid, overflow, count);
endinterface

// File: rtl/pulse_analyzer.sv
// Measures high time and period of a pulse train, one strobe per complete period.
// Define PULSE_ANALYZER_SYNC_EN to pass din through a two-flop synchronizer first.
//
// state | meaning
// IDLE  | after reset, waiting for the input to be low
// ARMED | input seen low, waiting for the first rise (no strobe)
// HIGH  | input high, width and period counters running
// LOW   | input low, period counter running; next rise publishes
module pulse_analyzer #(
  parameter int PULSE_WIDTH_WIDTH  = 8,
  parameter int PULSE_PERIOD_WIDTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  pulse_analyzer_if.slave    pa
);
  localparam logic [PULSE_WIDTH_WIDTH-1:0]  WMAX = '1;
  localparam logic [PULSE_PERIOD_WIDTH-1:0] PMAX = '1;
  localparam logic [PULSE_WIDTH_WIDTH-1:0]  WONE = PULSE_WIDTH_WIDTH'(1);
  localparam logic [PULSE_PERIOD_WIDTH-1:0] PONE = PULSE_PERIOD_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  state_t                        state_q, state_d;
  logic                          d, d_q, d_d;
  logic [PULSE_WIDTH_WIDTH-1:0]  wcnt_q, wcnt_d, width_q, width_d, w_inc;
  logic [PULSE_PERIOD_WIDTH-1:0] pcnt_q, pcnt_d, period_q, period_d, p_inc;
  logic                          sticky_q, sticky_d;
  logic                          valid_q, valid_d;
  logic                          ovf_q, ovf_d;
  logic [31:0]                   count_q, count_d;
  logic                          rise, fall;

`ifdef PULSE_ANALYZER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], pa.din};
  end

  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= sync_d;
  end

  assign d = sync_q[1];
`else
  assign d = pa.din;
`endif

  assign rise  = d & ~d_q;
  assign fall  = ~d & d_q;
  // Counters stick at all-ones rather than wrapping.
  assign w_inc = (wcnt_q == WMAX) ? WMAX : wcnt_q + WONE;
  assign p_inc = (pcnt_q == PMAX) ? PMAX : pcnt_q + PONE;

  always_comb begin
    state_d  = state_q;
    d_d      = d;
    wcnt_d   = wcnt_q;
    pcnt_d   = pcnt_q;
    sticky_d = sticky_q;
    width_d  = width_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (!d) state_d = ARMED;
      end
      ARMED: begin
        if (rise) begin
          state_d  = HIGH;
          wcnt_d   = WONE;
          pcnt_d   = PONE;
          sticky_d = 1'b0;
        end
      end
      HIGH: begin
        pcnt_d   = p_inc;
        sticky_d = sticky_q | (p_inc == PMAX);
        if (fall) begin
          state_d = LOW;
        end else begin
          wcnt_d   = w_inc;
          sticky_d = sticky_q | (p_inc == PMAX) | (w_inc == WMAX);
        end
      end
      LOW: begin
        if (rise) begin
          width_d  = wcnt_q;
          period_d = pcnt_q;
          ovf_d    = sticky_q;
          valid_d  = 1'b1;
          count_d  = count_q + 32'd1;
          wcnt_d   = WONE;
          pcnt_d   = PONE;
          sticky_d = 1'b0;
          state_d  = HIGH;
        end else begin
          pcnt_d   = p_inc;
          sticky_d = sticky_q | (p_inc == PMAX);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      d_q      <= 1'b1;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      sticky_q <= 1'b0;
      width_q  <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      wcnt_q   <= wcnt_d;
      pcnt_q   <= pcnt_d;
      sticky_q <= sticky_d;
      width_q  <= width_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign pa.width    = width_q;
  assign pa.period   = period_q;
  assign pa.overflow = ovf_q;
  assign pa.valid    = valid_q;
  assign pa.count    = count_q;
endmodule

// File: tb/tb_pulse_analyzer.sv
// Scoreboard bench for pulse_analyzer: stimulus pushes expected strobes, a monitor pops on valid.
`timescale 1ns/1ps
module tb_pulse_analyzer;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pulse_analyzer_if #(.PULSE_WIDTH_WIDTH(8), .PULSE_PERIOD_WIDTH(16)) pa ();

  pulse_analyzer #(.PULSE_WIDTH_WIDTH(8), .PULSE_PERIOD_WIDTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pa     (pa.slave)
  );

  typedef struct {
    logic [7:0]  w;
    logic [15:0] p;
    logic        ovf;
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (pa.valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got w=%0d p=%0d ovf=%0b cnt=%0d, required none",
                 pa.width, pa.period, pa.overflow, pa.count);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (pa.width !== e.w || pa.period !== e.p || pa.overflow !== e.ovf || pa.count !== e.cnt) begin
          errors++;
          $display("FAIL strobe_value: got w=%0d p=%0d ovf=%0b cnt=%0d, required w=%0d p=%0d ovf=%0b cnt=%0d",
                   pa.width, pa.period, pa.overflow, pa.count, e.w, e.p, e.ovf, e.cnt);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - last_cyc != e.gap) begin
            errors++;
            $display("FAIL strobe_spacing: got %0d cycles, required %0d", cyc - last_cyc, e.gap);
          end
        end
      end
      last_cyc = cyc;
    end
  end

  // Holds din at v for n sampling edges; entered and left at posedge+1.
  task automatic hold(input logic v, input int n);
    pa.din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic [7:0] w, input logic [15:0] p, input logic o, input int gap);
    exp_t e;
    e.w   = w;
    e.p   = p;
    e.ovf = o;
    e.gap = (strobes == 0) ? 0 : gap;
    strobes++;
    e.cnt = strobes;
    q.push_back(e);
  endtask

  // n generator periods: every rise after the first closes a (w,p) measurement.
  task automatic gen(input int w, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) expect_strobe(8'(w), 16'(p), 1'b0, p);
      hold(1'b1, w);
      hold(1'b0, p - w);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (pa.width !== 8'd0 || pa.period !== 16'd0 || pa.valid !== 1'b0 ||
        pa.overflow !== 1'b0 || pa.count !== 32'd0) begin
      errors++;
      $display("FAIL %s: got w=%0d p=%0d v=%0b ovf=%0b cnt=%0d, required all 0",
               name, pa.width, pa.period, pa.valid, pa.overflow, pa.count);
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (pa.count !== 32'(strobes)) begin
      errors++;
      $display("FAIL %s: got count=%0d, required %0d", name, pa.count, strobes);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    strobes = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    pa.din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_values");
    resetn = 1'b1;

    // W=3, P=10 for five periods
    hold(1'b0, 5);
    gen(3, 10, 5);
    hold(1'b0, 5);
    check_count("count_after_w3p10");

    // Narrowest pattern
    hold(1'b0, 5);
    do_reset();
    hold(1'b0, 3);
    gen(1, 2, 6);
    hold(1'b0, 5);

    // Widest pattern for P=10
    do_reset();
    hold(1'b0, 3);
    gen(9, 10, 4);
    hold(1'b0, 5);

    // din high across reset release
    pa.din = 1'b1;
    do_reset();
    check_zero("reset_din_high");
    hold(1'b1, 20);
    hold(1'b0, 4);
    gen(4, 8, 3);
    hold(1'b0, 5);

    // Period saturation, then a normal period clears overflow
    do_reset();
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 70000);
    expect_strobe(8'd1, 16'hFFFF, 1'b1, 0);
    gen(2, 5, 2);
    hold(1'b0, 5);

    // Width saturation
    do_reset();
    hold(1'b0, 3);
    hold(1'b1, 300);
    hold(1'b0, 100);
    expect_strobe(8'hFF, 16'd400, 1'b1, 0);
    hold(1'b1, 2);
    hold(1'b0, 3);
    hold(1'b0, 5);

    // Reset in the middle of HIGH
    do_reset();
    hold(1'b0, 3);
    gen(3, 6, 2);
    expect_strobe(8'd3, 16'd6, 1'b0, 6);
    hold(1'b1, 4);
    check_count("count_before_mid_reset");
    do_reset();
    check_zero("mid_high_reset");
    hold(1'b1, 3);
    hold(1'b0, 4);
    gen(3, 6, 3);
    hold(1'b0, 10);
    check_count("count_after_mid_reset");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: got %0d outstanding, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
